result_readout_ctrl: RTL and testbench

Sequencer that snapshots the six 64-bit correlator accumulators and the status bits on host request. It streams them as a fixed byte frame to the UART transmitter over a valid/ready handshake. It sits between the computation core / status register and the UART TX path. It makes readout atomic, so the host never sees a word torn by an ongoing accumulation.

---
 rtl/result_readout_ctrl.sv | 173 +++++++++++++++++
 tb/tb_result_readout_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/result_readout_ctrl.sv
// Readout sequencer: snapshots the six correlator accumulators plus status on
// request and streams them as a 51-byte checksummed frame over valid/ready.
module result_readout_ctrl #(
    parameter logic [7:0]  HEADER = 8'hA5,
    parameter int unsigned NWORDS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [1:0]  sr_in,
    input  logic [63:0] sum_x_2,
    input  logic [63:0] sum_y_2,
    input  logic [63:0] sum_xy,
    input  logic [63:0] sum_xy90,
    input  logic [63:0] sum_y90_2,
    input  logic [63:0] sum_y_y90,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        busy,
    output logic        frame_done
);

    // Handshake: a byte moves on every rising edge where tx_valid && tx_ready.
    // While tx_valid is high and tx_ready low, tx_valid and tx_data hold;
    // tx_valid stays high from the header to the checksum byte, and tx_ready
    // seen while tx_valid is low has no effect.

    localparam int unsigned NBYTES   = NWORDS * 8;
    localparam int unsigned SHADOW_W = NWORDS * 64;
    // Byte index of the last data byte; the checksum follows it.
    localparam logic [5:0]  LAST_DATA_IDX = 6'(NBYTES + 1);
    localparam logic [5:0]  CSUM_IDX      = 6'(NBYTES + 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SEND = 2'd2,
        S_LAST = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [SHADOW_W-1:0] shadow;
    logic [1:0]          sr_shadow;

    logic [5:0] idx;
    logic [5:0] idx_nxt;
    logic [5:0] idx_inc;
    logic [7:0] csum;
    logic [7:0] csum_nxt;
    logic [7:0] tx_data_nxt;
    logic       tx_valid_nxt;
    logic       busy_nxt;
    logic       frame_done_nxt;
    logic [7:0] next_byte;
    logic       xfer;

    assign xfer    = tx_valid & tx_ready;
    assign idx_inc = idx + 6'd1;

    // Word 0 sits in the top bits so byte d of the payload is simply the d-th
    // byte counted from the MSB end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow    <= '0;
            sr_shadow <= '0;
        end else if (state == S_IDLE && req) begin
            shadow    <= {sum_x_2, sum_y_2, sum_xy, sum_xy90, sum_y90_2, sum_y_y90};
            sr_shadow <= sr_in;
        end
    end

    // Byte that follows the one currently on tx_data (index 1 = status).
    always_comb begin
        next_byte = 8'h00;
        if (idx_inc == 6'd1) begin
            next_byte = {6'b0, sr_shadow};
        end
        for (int i = 0; i < int'(NBYTES); i++) begin
            if (idx_inc == 6'(i + 2)) begin
                next_byte = shadow[SHADOW_W-1-8*i -: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (req) state_nxt = S_LOAD;
            S_LOAD: state_nxt = S_SEND;
            S_SEND: if (xfer && idx == LAST_DATA_IDX) state_nxt = S_LAST;
            S_LAST: if (xfer) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        idx_nxt        = idx;
        csum_nxt       = csum;
        tx_data_nxt    = tx_data;
        tx_valid_nxt   = tx_valid;
        busy_nxt       = busy;
        frame_done_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    busy_nxt = 1'b1;
                end
            end
            S_LOAD: begin
                tx_data_nxt  = HEADER;
                tx_valid_nxt = 1'b1;
                csum_nxt     = 8'h00;
                idx_nxt      = 6'd0;
            end
            S_SEND: begin
                if (xfer) begin
                    // The header is not part of the checksum.
                    if (idx != 6'd0) begin
                        csum_nxt = csum ^ tx_data;
                    end
                    if (idx == LAST_DATA_IDX) begin
                        tx_data_nxt = csum ^ tx_data;
                        idx_nxt     = CSUM_IDX;
                    end else begin
                        tx_data_nxt = next_byte;
                        idx_nxt     = idx_inc;
                    end
                end
            end
            S_LAST: begin
                if (xfer) begin
                    tx_valid_nxt   = 1'b0;
                    busy_nxt       = 1'b0;
                    frame_done_nxt = 1'b1;
                end
            end
            default: begin
                tx_valid_nxt = 1'b0;
                busy_nxt     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= 6'd0;
            csum       <= 8'h00;
            tx_data    <= 8'h00;
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            idx        <= idx_nxt;
            csum       <= csum_nxt;
            tx_data    <= tx_data_nxt;
            tx_valid   <= tx_valid_nxt;
            busy       <= busy_nxt;
            frame_done <= frame_done_nxt;
        end
    end

endmodule

// File: tb/tb_result_readout_ctrl.sv
// Bench for result_readout_ctrl: table of frame scenarios with hand-computed
// checksums, plus directed idle, req-while-busy and mid-frame reset sequences.
`timescale 1ns/1ps
module tb_result_readout_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [1:0]  sr_in;
    logic [63:0] sum_x_2, sum_y_2, sum_xy, sum_xy90, sum_y90_2, sum_y_y90;
    logic        tx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        busy;
    logic        frame_done;

    result_readout_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .sr_in      (sr_in),
        .sum_x_2    (sum_x_2),
        .sum_y_2    (sum_y_2),
        .sum_xy     (sum_xy),
        .sum_xy90   (sum_xy90),
        .sum_y90_2  (sum_y90_2),
        .sum_y_y90  (sum_y_y90),
        .tx_ready   (tx_ready),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [0:5][63:0] w;
        logic [1:0]       sr;
        int               bp;        // 0: always ready, 1: random backpressure
        bit               corrupt;   // overwrite inputs after the snapshot
        bit               req_busy;  // pulse req at byte 20 and at the checksum
        logic [7:0]       exp_csum;
    } vec_t;

    vec_t       vecs[6];
    logic [7:0] exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_words(input logic [0:5][63:0] w, input logic [1:0] sr);
        sum_x_2   = w[0];
        sum_y_2   = w[1];
        sum_xy    = w[2];
        sum_xy90  = w[3];
        sum_y90_2 = w[4];
        sum_y_y90 = w[5];
        sr_in     = sr;
    endtask

    // Starts and ends just after a falling edge.
    task automatic run_frame(input vec_t vv, input int rst_at);
        int         got;
        int         cyc;
        int         stretch;
        bit         stall;
        bit         rdy;
        logic [7:0] held;
        logic [7:0] e;
        logic [0:5][63:0] ones;

        ones = '1;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back({6'b0, vv.sr});
        for (int k = 0; k < 6; k++)
            for (int b = 0; b < 8; b++)
                exp_q.push_back(vv.w[k][63-8*b -: 8]);
        exp_q.push_back(vv.exp_csum);

        set_words(vv.w, vv.sr);
        tx_ready = 1'b0;
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        if (vv.corrupt) set_words(ones, 2'b00);
        check("valid_after_1_cycle", 64'(tx_valid), 64'd0);
        check("busy_after_req", 64'(busy), 64'd1);
        @(negedge clk);
        check("valid_after_2_cycles", 64'(tx_valid), 64'd1);

        got = 0; cyc = 0; stretch = 0; stall = 0; held = 8'h00;
        while (got < 51 && cyc < 3000) begin
            check("valid_held", 64'(tx_valid), 64'd1);
            check("busy_held", 64'(busy), 64'd1);
            if (stall) check("stall_data_stable", 64'(tx_data), 64'(held));
            if (rst_at >= 0 && got == rst_at) begin
                #2 rst = 1'b1;
                #1;
                check("rst_async_valid", 64'(tx_valid), 64'd0);
                check("rst_async_busy", 64'(busy), 64'd0);
                check("rst_async_data", 64'(tx_data), 64'h00);
                @(negedge clk);
                rst = 1'b0;
                tx_ready = 1'b0;
                exp_q.delete();
                return;
            end
            if (vv.bp == 0) begin
                rdy = 1'b1;
            end else if (stretch > 0) begin
                rdy = 1'b0;
                stretch--;
            end else if ($urandom_range(0, 15) == 0) begin
                rdy = 1'b0;
                stretch = 19;
            end else begin
                rdy = 1'($urandom_range(0, 1));
            end
            if (vv.corrupt) set_words(ones, 2'b00);
            req = (vv.req_busy && (got == 20 || got == 50)) ? 1'b1 : 1'b0;
            tx_ready = rdy;
            if (tx_valid && rdy) begin
                if (exp_q.size() == 0) begin
                    check("exp_q_underflow", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("byte_%0d", got), 64'(tx_data), 64'(e));
                end
                got++;
                stall = 1'b0;
            end else begin
                stall = tx_valid;
                held  = tx_data;
            end
            @(negedge clk);
            cyc++;
        end
        req = 1'b0;
        tx_ready = 1'b0;
        if (got < 51) check("frame_timeout", 64'(got), 64'd51);
        if (vv.bp == 0) check("consecutive_cycles", 64'(cyc), 64'd51);
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        check("frame_done_pulse", 64'(frame_done), 64'd1);
        check("busy_fall", 64'(busy), 64'd0);
        check("valid_fall", 64'(tx_valid), 64'd0);
        @(negedge clk);
        check("frame_done_one_cycle", 64'(frame_done), 64'd0);
        if (vv.req_busy) begin
            tx_ready = 1'b1;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                check("no_second_frame_valid", 64'(tx_valid), 64'd0);
                check("no_second_frame_busy", 64'(busy), 64'd0);
            end
            tx_ready = 1'b0;
        end
    endtask

    initial begin
        vec_t basic;

        basic.w        = '0;
        basic.w[0]     = 64'h0102030405060708;
        basic.sr       = 2'b01;
        basic.bp       = 0;
        basic.corrupt  = 1'b0;
        basic.req_busy = 1'b0;
        basic.exp_csum = 8'h09;

        vecs[0] = basic;
        vecs[1] = basic;
        vecs[1].bp = 1;
        vecs[2] = basic;
        vecs[2].w = '0;
        vecs[2].sr = 2'b10;
        vecs[2].exp_csum = 8'h02;
        vecs[3] = basic;
        vecs[3].w = '0;
        vecs[3].w[1] = 64'h0000_0000_0000_00AA;
        vecs[3].w[5] = 64'h5500_0000_0000_0000;
        vecs[3].sr = 2'b11;
        vecs[3].bp = 1;
        vecs[3].corrupt = 1'b1;
        vecs[3].exp_csum = 8'hFC;
        vecs[4] = basic;
        for (int k = 0; k < 6; k++) vecs[4].w[k] = 64'h1111_1111_1111_1111;
        vecs[4].exp_csum = 8'h01;
        vecs[5] = basic;
        vecs[5].req_busy = 1'b1;

        rst = 1'b1;
        req = 1'b0;
        tx_ready = 1'b0;
        set_words('0, 2'b00);
        repeat (3) @(negedge clk);
        check("reset_tx_valid", 64'(tx_valid), 64'd0);
        check("reset_tx_data", 64'(tx_data), 64'h00);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_frame_done", 64'(frame_done), 64'd0);
        rst = 1'b0;

        tx_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle_valid", 64'(tx_valid), 64'd0);
            check("idle_busy", 64'(busy), 64'd0);
            check("idle_frame_done", 64'(frame_done), 64'd0);
        end
        tx_ready = 1'b0;

        for (int v = 0; v < 6; v++) begin
            run_frame(vecs[v], -1);
            repeat (2) @(negedge clk);
        end

        // Abandon a frame at byte 30, then a fresh frame must be complete.
        run_frame(vecs[0], 30);
        @(negedge clk);
        check("post_rst_valid", 64'(tx_valid), 64'd0);
        check("post_rst_done", 64'(frame_done), 64'd0);
        run_frame(vecs[0], -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
